// File: rtl/cpu_port_bank.sv
// cpu_port_bank: bank of CHANNELS bidirectional port channels, each with a
// direction (DDR) register and an output-value register on a simple CPU bus.
// Reads return the DDR register or a per-bit mix of the value register
// (output bits) and synchronized pin levels (input bits).
// Optional feature: define CPUPORT_FADE_EN to let a bit that is switched from
// output to input keep reading back its last driven level for FADE_CYCLES
// cycles before it follows the pin.
module cpu_port_bank #(
    parameter int               CHANNELS    = 2,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DDR_RESET   = '1,
    parameter logic [WIDTH-1:0] VALUE_RESET = WIDTH'('h3F),
    parameter int               FADE_CYCLES = 16,
    // Two registers per channel; CHANNELS >= 1 keeps this at least 1 bit.
    localparam int              AW          = $clog2(2 * CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ready,
    input  logic                      cs,
    input  logic [AW-1:0]             addr,
    input  logic                      bus_write,
    input  logic [WIDTH-1:0]          data_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      cpuport_ready,
    input  logic [CHANNELS*WIDTH-1:0] pins_i,
    output logic [CHANNELS*WIDTH-1:0] cpuport_ddr,
    output logic [CHANNELS*WIDTH-1:0] cpuport_value
);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("cpu_port_bank: CHANNELS must be 1..8");
    end
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("cpu_port_bank: WIDTH must be 1..16");
    end
    if (FADE_CYCLES < 1) begin : g_bad_fade
        $error("cpu_port_bank: FADE_CYCLES must be >= 1");
    end

    logic                      wr_en;
    logic [CHANNELS*WIDTH-1:0] rd_val_bus;
    logic [WIDTH-1:0]          rd_next;

    assign wr_en = cs & ready & bus_write;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        localparam logic [AW-1:0] DDR_ADDR = AW'(2 * ch);
        localparam logic [AW-1:0] VAL_ADDR = AW'(2 * ch + 1);

        logic             ddr_we;
        logic             val_we;
        logic [WIDTH-1:0] ddr_q;
        logic [WIDTH-1:0] val_q;
        logic [WIDTH-1:0] sync_p1;
        logic [WIDTH-1:0] sync_p2;
        logic [WIDTH-1:0] in_bits;

        // Exact address match also rejects out-of-range addresses.
        assign ddr_we = wr_en && (addr == DDR_ADDR);
        assign val_we = wr_en && (addr == VAL_ADDR);

        // Channel registers: reset wins over a same-cycle write
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                ddr_q <= DDR_RESET;
                val_q <= VALUE_RESET;
            end else begin
                if (ddr_we) ddr_q <= data_i;
                if (val_we) val_q <= data_i;
            end
        end

        // Two-flop synchronizer for the asynchronous pin levels
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync_p1 <= '0;
                sync_p2 <= '0;
            end else begin
                sync_p1 <= pins_i[ch*WIDTH +: WIDTH];
                sync_p2 <= sync_p1;
            end
        end

`ifdef CPUPORT_FADE_EN
        localparam int CW = $clog2(FADE_CYCLES + 1);

        logic [CW-1:0]    fade_cnt [WIDTH];
        logic [WIDTH-1:0] fade_bit;

        // Fade counters: load on a 1->0 DDR change, cancel on 0->1, otherwise count down
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int b = 0; b < WIDTH; b++) fade_cnt[b] <= '0;
            end else begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (ddr_we && ddr_q[b] && !data_i[b])
                        fade_cnt[b] <= CW'(FADE_CYCLES);
                    else if (ddr_we && data_i[b])
                        fade_cnt[b] <= '0;
                    else if (fade_cnt[b] != '0)
                        fade_cnt[b] <= fade_cnt[b] - CW'(1);
                end
            end
        end

        // Capture the driven level at the moment a bit turns into an input
        always_ff @(posedge clk) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (ddr_we && ddr_q[b] && !data_i[b]) fade_bit[b] <= val_q[b];
            end
        end

        // Input bits show the captured level while their fade is running
        always_comb begin
            in_bits = sync_p2;
            for (int b = 0; b < WIDTH; b++) begin
                if (fade_cnt[b] != '0) in_bits[b] = fade_bit[b];
            end
        end
`else
        assign in_bits = sync_p2;
`endif

        assign rd_val_bus[ch*WIDTH +: WIDTH]    = (ddr_q & val_q) | (~ddr_q & in_bits);
        assign cpuport_ddr[ch*WIDTH +: WIDTH]   = ddr_q;
        assign cpuport_value[ch*WIDTH +: WIDTH] = val_q;
    end

    // Read mux over the pre-write register state; unmapped addresses read 0
    always_comb begin
        rd_next = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (addr == AW'(2 * ch))     rd_next = cpuport_ddr[ch*WIDTH +: WIDTH];
            if (addr == AW'(2 * ch + 1)) rd_next = rd_val_bus[ch*WIDTH +: WIDTH];
        end
    end

    // Registered read data and access acknowledge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_o        <= '0;
            cpuport_ready <= 1'b0;
        end else begin
            data_o        <= rd_next;
            cpuport_ready <= cs;
        end
    end

endmodule

// File: tb/tb_cpu_port_bank.sv
// Bench for cpu_port_bank: a register-level model of the port bank is checked
// against the default-parameter instance on every cycle, with literal values
// pinning the key scenarios; a 3-channel instance covers unmapped addresses.
`timescale 1ns/1ps
module tb_cpu_port_bank;

    localparam int FADE = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, ready, cs, bus_write;
    logic [1:0]  addr;
    logic [7:0]  data_i;
    logic [15:0] pins_i;
    logic [7:0]  data_o;
    logic        cpuport_ready;
    logic [15:0] cpuport_ddr, cpuport_value;

    logic        r2_reset_n, r2_ready, r2_cs, r2_write;
    logic [2:0]  r2_addr;
    logic [7:0]  r2_data_i;
    logic [23:0] r2_pins;
    logic [7:0]  r2_data_o;
    logic        r2_rdy;
    logic [23:0] r2_ddr, r2_val;

    cpu_port_bank #(.CHANNELS(2), .WIDTH(8), .DDR_RESET(8'hFF), .VALUE_RESET(8'h3F),
                    .FADE_CYCLES(FADE)) dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .cs(cs), .addr(addr),
        .bus_write(bus_write), .data_i(data_i), .data_o(data_o),
        .cpuport_ready(cpuport_ready), .pins_i(pins_i),
        .cpuport_ddr(cpuport_ddr), .cpuport_value(cpuport_value)
    );

    cpu_port_bank #(.CHANNELS(3), .WIDTH(8), .DDR_RESET(8'hFF), .VALUE_RESET(8'h3F),
                    .FADE_CYCLES(FADE)) dut3 (
        .clk(clk), .reset_n(r2_reset_n), .ready(r2_ready), .cs(r2_cs), .addr(r2_addr),
        .bus_write(r2_write), .data_i(r2_data_i), .data_o(r2_data_o),
        .cpuport_ready(r2_rdy), .pins_i(r2_pins),
        .cpuport_ddr(r2_ddr), .cpuport_value(r2_val)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    string tag = "init";

    // Model state: registers, the pin levels seen one and two edges ago,
    // and for each bit the last edge number at which it still fades.
    logic [7:0]  m_ddr [2];
    logic [7:0]  m_val [2];
    logic [15:0] m_s1, m_s2;
    int          fade_until [2][8];
    logic        m_latch [2][8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int a);
        logic [7:0] r;
        int ch;
        r = 8'h00;
        if (a >= 4) return r;
        ch = a / 2;
        if (a % 2 == 0) return m_ddr[ch];
        for (int b = 0; b < 8; b++) begin
            if (m_ddr[ch][b])              r[b] = m_val[ch][b];
            else if (cyc <= fade_until[ch][b]) r[b] = m_latch[ch][b];
            else                           r[b] = m_s2[ch*8 + b];
        end
        return r;
    endfunction

    // One clock: predict the post-edge outputs, step the edge, compare
    task automatic tick();
        logic [7:0] e_data;
        logic       e_rdy;
        int         ch;
        cyc++;
        if (!reset_n) begin
            e_data = 8'h00;
            e_rdy  = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_ddr[c] = 8'hFF;
                m_val[c] = 8'h3F;
                for (int b = 0; b < 8; b++) fade_until[c][b] = -1;
            end
            m_s1 = '0;
            m_s2 = '0;
        end else begin
            e_data = model_read(int'(addr));
            e_rdy  = cs;
            if (cs && ready && bus_write) begin
                ch = int'(addr) / 2;
                if (addr[0] == 1'b0) begin
`ifdef CPUPORT_FADE_EN
                    for (int b = 0; b < 8; b++) begin
                        if (m_ddr[ch][b] && !data_i[b]) begin
                            fade_until[ch][b] = cyc + FADE;
                            m_latch[ch][b]    = m_val[ch][b];
                        end else if (data_i[b]) begin
                            fade_until[ch][b] = -1;
                        end
                    end
`endif
                    m_ddr[ch] = data_i;
                end else begin
                    m_val[ch] = data_i;
                end
            end
            m_s2 = m_s1;
            m_s1 = pins_i;
        end
        @(posedge clk);
        #1;
        check({tag, " data_o"}, data_o, e_data);
        check({tag, " ready"}, cpuport_ready, e_rdy);
        check({tag, " ddr"}, cpuport_ddr, {m_ddr[1], m_ddr[0]});
        check({tag, " value"}, cpuport_value, {m_val[1], m_val[0]});
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; ready = 1'b1; bus_write = 1'b1; addr = a; data_i = d;
        tick();
        cs = 1'b0; ready = 1'b0; bus_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        cs = 1'b1; ready = 1'b1; bus_write = 1'b0; addr = a;
        tick();
        cs = 1'b0; ready = 1'b0;
    endtask

    task automatic idle(input int n);
        cs = 1'b0; ready = 1'b0; bus_write = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] exp8;
        reset_n = 1'b0; ready = 1'b0; cs = 1'b0; bus_write = 1'b0;
        addr = '0; data_i = '0; pins_i = '0;
        r2_reset_n = 1'b0; r2_ready = 1'b0; r2_cs = 1'b0; r2_write = 1'b0;
        r2_addr = '0; r2_data_i = '0; r2_pins = '0;

        // Reset state; a write during reset must be discarded
        tag = "reset";
        idle(2);
        cs = 1'b1; ready = 1'b1; bus_write = 1'b1; addr = 2'd1; data_i = 8'h00;
        tick();
        check("reset data_o", data_o, 8'h00);
        check("reset ready", cpuport_ready, 1'b0);
        check("reset ddr", cpuport_ddr, 16'hFFFF);
        check("reset value", cpuport_value, 16'h3F3F);
        reset_n = 1'b1;
        idle(1);

        // Post-reset reads of all four registers
        tag = "rd_reset";
        rd(2'd0); check("rd0 FF", data_o, 8'hFF); check("rd0 ack", cpuport_ready, 1'b1);
        rd(2'd1); check("rd1 3F", data_o, 8'h3F);
        rd(2'd2); check("rd2 FF", data_o, 8'hFF);
        rd(2'd3); check("rd3 3F", data_o, 8'h3F);
        idle(1);
        check("ack drops", cpuport_ready, 1'b0);

        // Write without ready is ignored
        tag = "noready";
        cs = 1'b1; ready = 1'b0; bus_write = 1'b1; addr = 2'd1; data_i = 8'h00;
        tick();
        check("noready value0", cpuport_value[7:0], 8'h3F);
        idle(1);

        // Same-cycle write and read returns the old value
        tag = "rdwr";
        wr(2'd1, 8'h55);
        check("rdwr old", data_o, 8'h3F);
        rd(2'd1);
        check("rdwr new", data_o, 8'h55);

        // Mixed direction read with pins on channel 0
        tag = "mixed";
        wr(2'd0, 8'h0F);
        wr(2'd1, 8'hA5);
        pins_i[7:0] = 8'hC3;
        idle(20);
        rd(2'd1); check("mixed C5", data_o, 8'hC5);
        rd(2'd2); check("mixed ch1 ddr", data_o, 8'hFF);
        rd(2'd3); check("mixed ch1 val", data_o, 8'h3F);

        // Output-to-input switch with pins low
        tag = "fade";
        pins_i = '0;
        idle(4);
        wr(2'd1, 8'hFF);
        wr(2'd0, 8'hFF);
        wr(2'd0, 8'h00);
        cs = 1'b1; ready = 1'b1; bus_write = 1'b0; addr = 2'd1;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef CPUPORT_FADE_EN
            exp8 = (i <= FADE) ? 8'hFF : 8'h00;
`else
            exp8 = 8'h00;
`endif
            check($sformatf("fade rd %0d", i), data_o, exp8);
        end
        idle(1);

        // Value write during a fade leaves the retained level alone
        tag = "fade_val";
        wr(2'd0, 8'hFF);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h00);
        rd(2'd1);
`ifdef CPUPORT_FADE_EN
        check("fade keeps latch", data_o, 8'hFF);
`else
        check("no fade pins", data_o, 8'h00);
`endif
        wr(2'd0, 8'hFF);
        rd(2'd1);
        check("ddr set mid-fade", data_o, 8'h00);

        // Reset in the middle of a fade
        tag = "fade_rst";
        wr(2'd1, 8'hFF);
        wr(2'd0, 8'h00);
        rd(2'd1);
`ifdef CPUPORT_FADE_EN
        check("pre-reset fade", data_o, 8'hFF);
`else
        check("pre-reset pins", data_o, 8'h00);
`endif
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rd(2'd1);
        check("post-reset 3F", data_o, 8'h3F);

        // Synchronizer latency on channel 1; channel 0 untouched
        tag = "sync";
        wr(2'd2, 8'h00);
        idle(20);
        cs = 1'b1; ready = 1'b1; bus_write = 1'b0; addr = 2'd3;
        pins_i[15:8] = 8'h5A;
        tick(); check("sync edge1", data_o, 8'h00);
        tick(); check("sync edge2", data_o, 8'h00);
        tick(); check("sync edge3", data_o, 8'h5A);
        check("ch0 ddr intact", cpuport_ddr[7:0], 8'hFF);
        check("ch0 val intact", cpuport_value[7:0], 8'h3F);
        idle(1);

        // Three-channel instance: addresses 6 and 7 are unmapped
        tag = "ch3";
        tick();
        check("c3 reset data", r2_data_o, 8'h00);
        check("c3 reset ack", r2_rdy, 1'b0);
        check("c3 reset ddr", r2_ddr, 24'hFFFFFF);
        check("c3 reset val", r2_val, 24'h3F3F3F);
        r2_reset_n = 1'b1;
        r2_cs = 1'b1; r2_ready = 1'b1; r2_write = 1'b1; r2_addr = 3'd6; r2_data_i = 8'h00;
        tick();
        check("c3 wr6 data", r2_data_o, 8'h00);
        check("c3 wr6 ack", r2_rdy, 1'b1);
        r2_addr = 3'd7;
        tick();
        check("c3 wr7 data", r2_data_o, 8'h00);
        check("c3 wr67 ddr", r2_ddr, 24'hFFFFFF);
        check("c3 wr67 val", r2_val, 24'h3F3F3F);
        r2_addr = 3'd4; r2_data_i = 8'h12;
        tick();
        check("c3 wr4 old", r2_data_o, 8'hFF);
        r2_write = 1'b0; r2_addr = 3'd6;
        tick();
        check("c3 rd6", r2_data_o, 8'h00);
        check("c3 ddr2", r2_ddr, 24'h12FFFF);
        r2_cs = 1'b0;
        tick();
        check("c3 ack off", r2_rdy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
